ldst_queue: RTL and testbench

Parametrised in-order load/store queue for the OoO core. It holds decoded memory ops in program order and captures operands from a multi-port common data bus. It issues one op at a time to the D-cache port, holding stores until they reach the ROB head, and broadcasts results tagged with their ROB index. It sits between decode/dispatch and the D-cache and supports pipeline flush, including flush while a cache access is in flight.

---
 rtl/rv32i_types.sv | 27 ++
 rtl/ldst_align.sv | 38 +++
 rtl/ldst_queue.sv | 229 ++++++++++++++++++++++
 tb/tb_ldst_queue.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared memory-op types for the load/store path: op encoding, queue entry
// layout and a store classifier.
package rv32i_types;

  typedef enum logic [2:0] {
    MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_ops;

  // Entry tags are stored zero-extended to this width; only the low ROB tag
  // bits of the instantiating queue are ever non-zero.
  localparam int TAG_W = 8;

  typedef struct packed {
    mem_ops            memop;
    logic [31:0]       base;
    logic              base_v;
    logic [31:0]       data;
    logic              data_v;
    logic [31:0]       imm;
    logic [TAG_W-1:0]  tag;
  } ldst_entry_t;

  function automatic logic is_store(input mem_ops op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

endpackage

// File: rtl/ldst_align.sv
// Byte-lane steering between a memory op and a 32-bit word port: byte
// enables, shifted store data and extended load value.
module ldst_align
  import rv32i_types::*;
(
  input  mem_ops      memop,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_value
);

  logic [3:0]  mask;
  logic [31:0] shifted;

  always_comb begin
    unique case (memop)
      MEM_LB, MEM_LBU, MEM_SB: mask = 4'b0001;
      MEM_LH, MEM_LHU, MEM_SH: mask = 4'b0011;
      default:                 mask = 4'b1111;
    endcase
    // Lanes pushed past byte 3 simply fall off: misaligned accesses are
    // truncated to the addressed word rather than trapping.
    be      = mask << off;
    wdata   = st_data << {off, 3'b000};
    shifted = rdata >> {off, 3'b000};
    unique case (memop)
      MEM_LB:  ld_value = {{24{shifted[7]}}, shifted[7:0]};
      MEM_LBU: ld_value = {24'h0, shifted[7:0]};
      MEM_LH:  ld_value = {{16{shifted[15]}}, shifted[15:0]};
      MEM_LHU: ld_value = {16'h0, shifted[15:0]};
      default: ld_value = shifted;
    endcase
  end

endmodule

// File: rtl/ldst_queue.sv
// In-order load/store queue: captures operands from the CDB, issues the head
// op to the D-cache one at a time and broadcasts its result by ROB tag.
module ldst_queue
  import rv32i_types::*;
#(
  parameter int DEPTH     = 8,
  parameter int IDX_BITS  = $clog2(DEPTH),
  parameter int ROB_BITS  = 4,
  parameter int CDB_PORTS = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               alloc_valid,
  output logic                               alloc_ready,
  input  mem_ops                             alloc_memop,
  input  logic [31:0]                        alloc_base,
  input  logic [31:0]                        alloc_data,
  input  logic [31:0]                        alloc_imm,
  input  logic                               alloc_base_v,
  input  logic                               alloc_data_v,
  input  logic [ROB_BITS-1:0]                alloc_tag,
  input  logic [CDB_PORTS-1:0]               cdb_valid,
  input  logic [CDB_PORTS-1:0][ROB_BITS-1:0] cdb_tag,
  input  logic [CDB_PORTS-1:0][31:0]         cdb_data,
  input  logic [ROB_BITS-1:0]                rob_head_tag,
  output logic                               res_valid,
  output logic [ROB_BITS-1:0]                res_tag,
  output logic [31:0]                        res_data,
  output logic [IDX_BITS:0]                  count,
  output logic                               dmem_read,
  output logic                               dmem_write,
  output logic [31:0]                        dmem_addr,
  output logic [31:0]                        dmem_wdata,
  output logic [3:0]                         dmem_be,
  input  logic [31:0]                        dmem_rdata,
  input  logic                               dmem_resp
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_DRAIN} state_t;

  state_t              state_q;
  ldst_entry_t         ent_q [DEPTH];
  ldst_entry_t         ent_d [DEPTH];
  logic [DEPTH-1:0]    ent_v_q, ent_v_d;
  logic [IDX_BITS:0]   head_q, head_d, tail_q, tail_d;
  logic [IDX_BITS-1:0] head_idx, tail_idx;
  logic                full, empty, alloc_fire, complete, head_ready, issue;
  ldst_entry_t         head_ent, alloc_ent;
  logic [32:0]         base_w [DEPTH];
  logic [32:0]         data_w [DEPTH];
  logic [32:0]         alloc_base_w, alloc_data_w;
  logic [31:0]         ea, al_wdata, al_ld;
  logic [3:0]          al_be;

  logic                dmem_read_q, dmem_write_q, res_valid_q;
  logic [31:0]         dmem_addr_q, dmem_wdata_q, res_data_q;
  logic [3:0]          dmem_be_q;
  logic [ROB_BITS-1:0] res_tag_q;

  // Returns {valid, value}; on several matching ports the lowest index wins.
  function automatic logic [32:0] snoop(input logic [31:0] opnd, input logic opnd_v);
    logic [32:0] r;
    r = {opnd_v, opnd};
    if (!opnd_v) begin
      for (int p = CDB_PORTS - 1; p >= 0; p--) begin
        if (cdb_valid[p] && (cdb_tag[p] == opnd[ROB_BITS-1:0])) begin
          r = {1'b1, cdb_data[p]};
        end
      end
    end
    return r;
  endfunction

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wake
    assign base_w[gi] = snoop(ent_q[gi].base, ent_q[gi].base_v);
    assign data_w[gi] = snoop(ent_q[gi].data, ent_q[gi].data_v);
  end

  assign alloc_base_w = snoop(alloc_base, alloc_base_v);
  assign alloc_data_w = snoop(alloc_data, alloc_data_v);
  assign alloc_ent = '{memop:  alloc_memop,
                       base:   alloc_base_w[31:0],
                       base_v: alloc_base_w[32],
                       data:   alloc_data_w[31:0],
                       data_v: alloc_data_w[32],
                       imm:    alloc_imm,
                       tag:    TAG_W'(alloc_tag)};

  assign head_idx    = head_q[IDX_BITS-1:0];
  assign tail_idx    = tail_q[IDX_BITS-1:0];
  assign empty       = (head_q == tail_q);
  assign full        = (head_idx == tail_idx) && (head_q[IDX_BITS] != tail_q[IDX_BITS]);
  assign alloc_ready = !full;
  assign count       = tail_q - head_q;
  assign alloc_fire  = alloc_valid && !full && !flush;
  assign complete    = ((state_q == S_LOAD) || (state_q == S_STORE)) && dmem_resp;
  assign head_ent    = ent_q[head_idx];
  assign ea          = head_ent.base + head_ent.imm;

  // Stores may only touch memory once they are the oldest uncommitted op.
  always_comb begin
    head_ready = head_ent.base_v;
    if (is_store(head_ent.memop)) begin
      head_ready = head_ent.base_v && head_ent.data_v &&
                   (head_ent.tag == TAG_W'(rob_head_tag));
    end
  end

  assign issue = !empty && head_ready && !flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    ent_v_d = ent_v_q;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_v_q[i]) begin
        ent_d[i].base   = base_w[i][31:0];
        ent_d[i].base_v = base_w[i][32];
        ent_d[i].data   = data_w[i][31:0];
        ent_d[i].data_v = data_w[i][32];
      end
    end
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      ent_v_d = '0;
    end else begin
      if (alloc_fire) begin
        ent_d[tail_idx]   = alloc_ent;
        ent_v_d[tail_idx] = 1'b1;
        tail_d            = tail_q + 1'b1;
      end
      if (complete) begin
        ent_v_d[head_idx] = 1'b0;
        head_d            = head_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      ent_v_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      ent_v_q <= ent_v_d;
    end
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  // The head entry stays put while its access is outstanding, so one aligner
  // serves both request formatting and response extraction.
  ldst_align u_align (
    .memop    (head_ent.memop),
    .off      (ea[1:0]),
    .st_data  (head_ent.data),
    .rdata    (dmem_rdata),
    .be       (al_be),
    .wdata    (al_wdata),
    .ld_value (al_ld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      dmem_read_q  <= 1'b0;
      dmem_write_q <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_be_q    <= '0;
      res_valid_q  <= 1'b0;
      res_tag_q    <= '0;
      res_data_q   <= '0;
    end else begin
      res_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (issue) begin
            state_q      <= is_store(head_ent.memop) ? S_STORE : S_LOAD;
            dmem_read_q  <= !is_store(head_ent.memop);
            dmem_write_q <= is_store(head_ent.memop);
            dmem_addr_q  <= {ea[31:2], 2'b00};
            dmem_wdata_q <= al_wdata;
            dmem_be_q    <= al_be;
          end
        end
        S_LOAD, S_STORE: begin
          if (dmem_resp) begin
            state_q      <= S_IDLE;
            dmem_read_q  <= 1'b0;
            dmem_write_q <= 1'b0;
            res_valid_q  <= 1'b1;
            res_tag_q    <= ROB_BITS'(head_ent.tag);
            res_data_q   <= (state_q == S_LOAD) ? al_ld : 32'h0;
          end else if (flush) begin
            // The cache still owes a response; keep the request up and
            // swallow that response without retiring anything.
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (dmem_resp) begin
            state_q      <= S_IDLE;
            dmem_read_q  <= 1'b0;
            dmem_write_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dmem_read  = dmem_read_q;
  assign dmem_write = dmem_write_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign dmem_be    = dmem_be_q;
  assign res_valid  = res_valid_q;
  assign res_tag    = res_tag_q;
  assign res_data   = res_data_q;

endmodule

// File: tb/tb_ldst_queue.sv
// Directed and randomized bench for ldst_queue against a byte-level model of
// op addressing, lane selection and operand wakeup.
module tb_ldst_queue;
  import rv32i_types::*;

  localparam int DEPTH = 8, IDX_BITS = 3, ROB_BITS = 4, CDB_PORTS = 2;

  logic clk = 1'b0;
  logic rst, flush, alloc_valid, alloc_ready;
  mem_ops alloc_memop;
  logic [31:0] alloc_base, alloc_data, alloc_imm;
  logic alloc_base_v, alloc_data_v;
  logic [ROB_BITS-1:0] alloc_tag, rob_head_tag, res_tag;
  logic [CDB_PORTS-1:0] cdb_valid;
  logic [CDB_PORTS-1:0][ROB_BITS-1:0] cdb_tag;
  logic [CDB_PORTS-1:0][31:0] cdb_data;
  logic res_valid;
  logic [31:0] res_data, dmem_addr, dmem_wdata, dmem_rdata;
  logic [IDX_BITS:0] count;
  logic dmem_read, dmem_write, dmem_resp;
  logic [3:0] dmem_be;

  int checks = 0;
  int errors = 0;

  typedef struct {
    mem_ops      op;
    logic [31:0] base;
    logic        base_v;
    logic [31:0] data;
    logic        data_v;
    logic [31:0] imm;
    logic [3:0]  tag;
  } op_t;

  op_t mq[$];

  ldst_queue #(.DEPTH(DEPTH), .IDX_BITS(IDX_BITS), .ROB_BITS(ROB_BITS), .CDB_PORTS(CDB_PORTS)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_memop(alloc_memop),
    .alloc_base(alloc_base), .alloc_data(alloc_data), .alloc_imm(alloc_imm),
    .alloc_base_v(alloc_base_v), .alloc_data_v(alloc_data_v), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .rob_head_tag(rob_head_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data), .count(count),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_alloc(input op_t o);
    alloc_valid  = 1'b1;
    alloc_memop  = o.op;
    alloc_base   = o.base;
    alloc_base_v = o.base_v;
    alloc_data   = o.data;
    alloc_data_v = o.data_v;
    alloc_imm    = o.imm;
    alloc_tag    = o.tag;
    tick();
    alloc_valid  = 1'b0;
  endtask

  function automatic op_t mk(input mem_ops op, input logic [31:0] base, input logic bv,
                             input logic [31:0] data, input logic dv, input logic [31:0] imm,
                             input logic [3:0] tag);
    op_t o;
    o.op = op; o.base = base; o.base_v = bv; o.data = data; o.data_v = dv;
    o.imm = imm; o.tag = tag;
    return o;
  endfunction

  // Drive one CDB cycle; the model wakes every queued operand waiting on t.
  task automatic broadcast(input logic [3:0] t, input int port, input logic [31:0] d0,
                           input logic [31:0] d1, input bit both);
    logic [31:0] win;
    cdb_valid = '0;
    cdb_tag[port] = t;
    cdb_data[port] = d0;
    cdb_valid[port] = 1'b1;
    win = d0;
    if (both) begin
      cdb_tag[0] = t; cdb_tag[1] = t;
      cdb_data[0] = d0; cdb_data[1] = d1;
      cdb_valid = 2'b11;
    end
    foreach (mq[i]) begin
      if (!mq[i].base_v && mq[i].base[3:0] == t) begin mq[i].base = win; mq[i].base_v = 1'b1; end
      if (!mq[i].data_v && mq[i].data[3:0] == t) begin mq[i].data = win; mq[i].data_v = 1'b1; end
    end
    tick();
    cdb_valid = '0;
  endtask

  function automatic void model_op(input op_t o, input logic [31:0] rd, output logic w,
                                   output logic [31:0] addr, output logic [3:0] be,
                                   output logic [31:0] wd, output logic [31:0] res);
    logic [31:0] ea;
    int off, size;
    bit sgn;
    ea = o.base + o.imm;
    off = int'(ea[1:0]);
    w = 1'b0; size = 4; sgn = 1'b0;
    case (o.op)
      MEM_LB:  begin size = 1; sgn = 1'b1; end
      MEM_LH:  begin size = 2; sgn = 1'b1; end
      MEM_LBU: size = 1;
      MEM_LHU: size = 2;
      MEM_SB:  begin size = 1; w = 1'b1; end
      MEM_SH:  begin size = 2; w = 1'b1; end
      MEM_SW:  w = 1'b1;
      default: ;
    endcase
    addr = {ea[31:2], 2'b00};
    be = '0;
    res = '0;
    wd = o.data << (8 * off);
    for (int k = 0; k < size; k++) begin
      if (off + k < 4) begin
        be[off + k] = 1'b1;
        res[8*k +: 8] = rd[8*(off + k) +: 8];
      end
    end
    if (sgn && res[8*size - 1]) for (int b = 8 * size; b < 32; b++) res[b] = 1'b1;
    if (w) res = '0;
  endfunction

  task automatic wait_req(input string nm);
    int n = 0;
    while (!(dmem_read || dmem_write) && n < 50) begin tick(); n++; end
    chk({nm, "_req"}, 32'(dmem_read | dmem_write), 32'd1);
  endtask

  task automatic serve(input string nm, input logic ew, input logic [31:0] ea, input logic [3:0] ebe,
                       input logic [31:0] ewd, input logic [31:0] rd, input int dly,
                       input logic [31:0] eres, input logic [3:0] etag);
    wait_req(nm);
    chk({nm, "_rd"}, 32'(dmem_read), 32'(!ew));
    chk({nm, "_wr"}, 32'(dmem_write), 32'(ew));
    chk({nm, "_addr"}, dmem_addr, ea);
    chk({nm, "_be"}, 32'(dmem_be), 32'(ebe));
    if (ew) chk({nm, "_wdata"}, dmem_wdata, ewd);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk({nm, "_hold"}, {dmem_addr[31:2], dmem_be, 30'(dmem_read | dmem_write)},
          {ea[31:2], ebe, 30'd1});
    end
    dmem_rdata = rd;
    dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0;
    dmem_rdata = $urandom;
    chk({nm, "_rv"}, 32'(res_valid), 32'd1);
    chk({nm, "_tag"}, 32'(res_tag), 32'(etag));
    chk({nm, "_res"}, res_data, eres);
    chk({nm, "_reqoff"}, 32'(dmem_read | dmem_write), 32'd0);
  endtask

  task automatic run_front(input int idx);
    op_t o;
    logic w;
    logic [31:0] a, wd, res, rd;
    logic [3:0] be;
    o = mq[0];
    if (!o.base_v)
      broadcast(o.base[3:0], $urandom_range(0, 1), $urandom, $urandom, ($urandom_range(0, 2) == 0));
    o = mq[0];
    if (is_store(o.op) && !o.data_v)
      broadcast(o.data[3:0], $urandom_range(0, 1), $urandom, $urandom, ($urandom_range(0, 2) == 0));
    o = mq[0];
    rob_head_tag = o.tag;
    rd = $urandom;
    model_op(o, rd, w, a, be, wd, res);
    serve($sformatf("rnd%0d", idx), w, a, be, wd, rd, $urandom_range(0, 2), res, o.tag);
    void'(mq.pop_front());
  endtask

  initial begin
    logic [3:0] tag_ctr;
    int nops, opn;
    op_t o;

    rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_memop = MEM_LW;
    alloc_base = '0; alloc_data = '0; alloc_imm = '0; alloc_base_v = 1'b0; alloc_data_v = 1'b0;
    alloc_tag = '0; cdb_valid = '0; cdb_tag = '0; cdb_data = '0; rob_head_tag = '0;
    dmem_rdata = '0; dmem_resp = 1'b0;
    tick(); tick();
    chk("rst_ready", 32'(alloc_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_req", {30'd0, dmem_read, dmem_write}, 32'd0);
    chk("rst_res", {res_valid, 27'd0, res_tag}, 32'd0);
    chk("rst_data", res_data | dmem_addr | dmem_wdata, 32'd0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    rst = 1'b0;

    // lw with ready base
    do_alloc(mk(MEM_LW, 32'h100, 1'b1, 32'h0, 1'b1, 32'h4, 4'd1));
    chk("lw_count", 32'(count), 32'd1);
    serve("lw", 1'b0, 32'h104, 4'b1111, 32'h0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 4'd1);
    tick();
    chk("lw_pulse", 32'(res_valid), 32'd0);

    // lb / lbu on the top byte lane
    do_alloc(mk(MEM_LB, 32'h103, 1'b1, 32'h0, 1'b1, 32'h0, 4'd2));
    do_alloc(mk(MEM_LBU, 32'h100, 1'b1, 32'h0, 1'b1, 32'h3, 4'd3));
    serve("lb", 1'b0, 32'h100, 4'b1000, 32'h0, 32'h80123456, 1, 32'hFFFFFF80, 4'd2);
    serve("lbu", 1'b0, 32'h100, 4'b1000, 32'h0, 32'h80ABCDEF, 0, 32'h00000080, 4'd3);

    // sh waiting on a CDB data tag and then on the ROB head
    do_alloc(mk(MEM_SH, 32'h200, 1'b1, 32'h5, 1'b0, 32'h2, 4'd7));
    broadcast(4'd5, 1, 32'h1234, 32'h0, 1'b0);
    repeat (4) tick();
    chk("sh_wait", {30'd0, dmem_read, dmem_write}, 32'd0);
    rob_head_tag = 4'd7;
    serve("sh", 1'b1, 32'h200, 4'b1100, 32'h12340000, $urandom, 2, 32'h0, 4'd7);

    // fill, free one slot, then alloc with completion in the same cycle
    for (int i = 0; i < DEPTH; i++)
      do_alloc(mk(MEM_LW, 32'hA9, 1'b0, 32'h0, 1'b1, 32'(4 * i), 4'(i)));
    chk("full_ready", 32'(alloc_ready), 32'd0);
    chk("full_count", 32'(count), 32'(DEPTH));
    broadcast(4'd9, 0, 32'h400, 32'h0, 1'b0);
    serve("fill0", 1'b0, 32'h400, 4'b1111, 32'h0, 32'h11111111, 1, 32'h11111111, 4'd0);
    chk("free_ready", 32'(alloc_ready), 32'd1);
    chk("free_count", 32'(count), 32'(DEPTH - 1));
    wait_req("fill1");
    chk("fill1_addr", dmem_addr, 32'h404);
    alloc_valid = 1'b1; alloc_memop = MEM_LW; alloc_base = 32'h600; alloc_base_v = 1'b1;
    alloc_imm = 32'h0; alloc_tag = 4'd8; alloc_data_v = 1'b1;
    dmem_rdata = 32'h22222222; dmem_resp = 1'b1;
    tick();
    alloc_valid = 1'b0; dmem_resp = 1'b0;
    chk("wrap_count", 32'(count), 32'(DEPTH - 1));
    chk("wrap_res", res_data, 32'h22222222);
    chk("wrap_tag", {31'd0, res_valid} | {27'd0, res_tag, 1'b0}, {27'd0, 4'd1, 1'b1});
    for (int i = 2; i < DEPTH; i++) begin
      logic [31:0] v;
      v = $urandom;
      serve($sformatf("fill%0d", i), 1'b0, 32'(32'h400 + 4 * i), 4'b1111, 32'h0, v, 0, v, 4'(i));
    end
    serve("wrapnew", 1'b0, 32'h600, 4'b1111, 32'h0, 32'h33333333, 0, 32'h33333333, 4'd8);
    chk("drained_count", 32'(count), 32'd0);

    // flush while a load is outstanding; a same-cycle alloc is dropped
    rob_head_tag = 4'd5;
    do_alloc(mk(MEM_LW, 32'h300, 1'b1, 32'h0, 1'b1, 32'h0, 4'd4));
    do_alloc(mk(MEM_SW, 32'h700, 1'b1, 32'h55, 1'b1, 32'h0, 4'd5));
    wait_req("fl");
    flush = 1'b1;
    alloc_valid = 1'b1; alloc_memop = MEM_LW; alloc_base = 32'h900; alloc_base_v = 1'b1; alloc_tag = 4'd9;
    tick();
    flush = 1'b0; alloc_valid = 1'b0;
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_hold", 32'(dmem_read), 32'd1);
    tick(); tick();
    chk("fl_hold2", {dmem_addr[31:1], dmem_read}, {31'(32'h300 >> 1), 1'b1});
    dmem_rdata = 32'hBAD0BAD0; dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0;
    chk("fl_nores", 32'(res_valid), 32'd0);
    chk("fl_reqoff", {30'd0, dmem_read, dmem_write}, 32'd0);
    repeat (3) tick();
    chk("fl_idle", {30'd0, dmem_read, dmem_write} | 32'(res_valid), 32'd0);
    do_alloc(mk(MEM_LW, 32'h800, 1'b1, 32'h0, 1'b1, 32'h8, 4'd6));
    serve("postfl", 1'b0, 32'h808, 4'b1111, 32'h0, 32'h44444444, 0, 32'h44444444, 4'd6);

    // same-cycle CDB bypass at alloc
    alloc_valid = 1'b1; alloc_memop = MEM_LW; alloc_base = 32'h3; alloc_base_v = 1'b0;
    alloc_imm = 32'h10; alloc_tag = 4'd6;
    cdb_valid = 2'b01; cdb_tag[0] = 4'd3; cdb_data[0] = 32'h500;
    tick();
    alloc_valid = 1'b0; cdb_valid = '0;
    chk("byp_early", 32'(dmem_read), 32'd0);
    tick();
    chk("byp_issue", 32'(dmem_read), 32'd1);
    serve("byp", 1'b0, 32'h510, 4'b1111, 32'h0, 32'h66666666, 0, 32'h66666666, 4'd6);

    // randomized rounds
    tag_ctr = 4'd0;
    opn = 0;
    for (int r = 0; r < 14; r++) begin
      nops = $urandom_range(1, 4);
      for (int j = 0; j < nops; j++) begin
        o.op = mem_ops'($urandom_range(0, 7));
        o.base = $urandom;
        o.base_v = 1'($urandom_range(0, 1));
        o.data = $urandom;
        o.data_v = 1'($urandom_range(0, 1));
        o.imm = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15));
        o.tag = tag_ctr;
        tag_ctr = tag_ctr + 4'd1;
        do_alloc(o);
        mq.push_back(o);
      end
      chk($sformatf("rnd_count%0d", r), 32'(count), 32'(nops));
      while (mq.size() > 0) begin
        run_front(opn);
        opn++;
      end
    end
    chk("final_count", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
